dmem_arbiter: RTL and testbench

Sequences and shares the single-ported, fixed-latency data memory between the pipeline MEM stage (CPU port) and a debug/loader port (DBG port).
- Translates byte addresses to word indices and drives the memory for MEM_LAT cycles per access.
- Freezes the pipeline while a CPU access is pending.
- Round-robin arbitration between the two requesters.

---
 rtl/dmem_pkg.sv | 24 ++
 rtl/dmem_arbiter_if.sv | 54 +++++
 rtl/dmem_addr_xlate.sv | 30 +++
 rtl/dmem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory arbiter slice.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    typedef enum logic {
        OWN_CPU,
        OWN_DBG
    } owner_e;

    localparam int unsigned BASE_ADDR_DEF = 1024;
    localparam int unsigned DEPTH_DEF     = 64;

    // Word offset from the memory base; callers keep the low IDX_W bits.
    function automatic logic [31:0] addr_to_idx(input logic [31:0] addr,
                                                input logic [31:0] base);
        return (addr - base) >> 2;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// CPU, debug and memory-side signals of the data-memory arbiter.
// range_err exists only when DMEM_RANGE_CHECK_EN is defined.
interface dmem_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 6
);
    logic              cpu_rd_en;
    logic              cpu_wr_en;
    logic [31:0]       cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_freeze;

    logic              dbg_req;
    logic              dbg_we;
    logic [31:0]       dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic [DATA_W-1:0] dbg_rdata;
    logic              dbg_ack;

    logic              mem_en;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_idx;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
`ifdef DMEM_RANGE_CHECK_EN
    logic              range_err;
`endif

    modport slave (
`ifdef DMEM_RANGE_CHECK_EN
        output range_err,
`endif
        input  cpu_rd_en, cpu_wr_en, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_freeze,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_rdata, dbg_ack,
        output mem_en, mem_we, mem_idx, mem_wdata,
        input  mem_rdata
    );

    modport master (
`ifdef DMEM_RANGE_CHECK_EN
        input  range_err,
`endif
        output cpu_rd_en, cpu_wr_en, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_freeze,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_rdata, dbg_ack,
        input  mem_en, mem_we, mem_idx, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_addr_xlate.sv
// Byte address to memory word index; with DMEM_RANGE_CHECK_EN also
// reports whether the address falls inside the memory window.
module dmem_addr_xlate
    import dmem_pkg::*;
#(
    parameter int BASE_ADDR = BASE_ADDR_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int IDX_W     = $clog2(DEPTH)
) (
    input  logic [31:0]      addr,
`ifdef DMEM_RANGE_CHECK_EN
    output logic             in_range,
`endif
    output logic [IDX_W-1:0] idx
);

    logic [31:0] word_off;
    logic        unused_hi;

    assign word_off  = addr_to_idx(addr, 32'(BASE_ADDR));
    assign idx       = word_off[IDX_W-1:0];
    // Upper offset bits are dropped on purpose: the index wraps modulo DEPTH.
    assign unused_hi = ^word_off[31:IDX_W];

`ifdef DMEM_RANGE_CHECK_EN
    assign in_range = (addr >= 32'(BASE_ADDR)) &&
                      (addr <  32'(BASE_ADDR + 4 * DEPTH));
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin sharing of the fixed-latency data memory between the MEM
// stage and the debug port. Optional DMEM_RANGE_CHECK_EN adds range_err.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int BASE_ADDR = BASE_ADDR_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int MEM_LAT   = 2
) (
    input logic           clk,
    input logic           rst,
    dmem_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    owner_e            rr_q, rr_d;
    owner_e            pick;
    logic              we_q, we_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
    logic [IDX_W-1:0]  cpu_idx, dbg_idx;
    logic              cpu_req;
`ifdef DMEM_RANGE_CHECK_EN
    logic              cpu_in_rng, dbg_in_rng;
    logic              err_q, err_d;
`endif

    assign cpu_req = bus.cpu_rd_en | bus.cpu_wr_en;

    dmem_addr_xlate #(.BASE_ADDR(BASE_ADDR), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_cpu_xlate (
        .addr     (bus.cpu_addr),
`ifdef DMEM_RANGE_CHECK_EN
        .in_range (cpu_in_rng),
`endif
        .idx      (cpu_idx)
    );

    dmem_addr_xlate #(.BASE_ADDR(BASE_ADDR), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_dbg_xlate (
        .addr     (bus.dbg_addr),
`ifdef DMEM_RANGE_CHECK_EN
        .in_range (dbg_in_rng),
`endif
        .idx      (dbg_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_CPU;
            rr_q        <= OWN_CPU;
            we_q        <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
`ifdef DMEM_RANGE_CHECK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_q        <= rr_d;
            we_q        <= we_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
`ifdef DMEM_RANGE_CHECK_EN
            err_q       <= err_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_d        = rr_q;
        we_d        = we_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        pick        = OWN_CPU;
`ifdef DMEM_RANGE_CHECK_EN
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (cpu_req || bus.dbg_req) begin
                    // Contention is the only case that consumes the rr turn.
                    if (cpu_req && bus.dbg_req) begin
                        pick = rr_q;
                        rr_d = (rr_q == OWN_CPU) ? OWN_DBG : OWN_CPU;
                    end else if (cpu_req) begin
                        pick = OWN_CPU;
                    end else begin
                        pick = OWN_DBG;
                    end
                    owner_d = pick;
                    if (pick == OWN_CPU) begin
                        we_d    = bus.cpu_wr_en;
                        idx_d   = cpu_idx;
                        wdata_d = bus.cpu_wdata;
                    end else begin
                        we_d    = bus.dbg_we;
                        idx_d   = dbg_idx;
                        wdata_d = bus.dbg_wdata;
                    end
                    cnt_d   = CNT_W'(MEM_LAT - 1);
                    state_d = ACCESS;
`ifdef DMEM_RANGE_CHECK_EN
                    err_d = 1'b0;
                    if ((pick == OWN_CPU) ? !cpu_in_rng : !dbg_in_rng) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        if (!we_d) begin
                            if (pick == OWN_CPU) cpu_rdata_d = '0;
                            else                 dbg_rdata_d = '0;
                        end
                    end
`endif
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        if (owner_q == OWN_CPU) cpu_rdata_d = bus.mem_rdata;
                        else                    dbg_rdata_d = bus.mem_rdata;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_en     = (state_q == ACCESS);
        bus.mem_we     = (state_q == ACCESS) && we_q;
        bus.dbg_ack    = (state_q == RESP) && (owner_q == OWN_DBG);
        bus.cpu_freeze = cpu_req && !((state_q == RESP) && (owner_q == OWN_CPU));
`ifdef DMEM_RANGE_CHECK_EN
        bus.range_err  = (state_q == RESP) && err_q;
`endif
    end

    assign bus.mem_idx   = idx_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural memory preloaded mem[i]=i.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 64;
    localparam int IDX_W  = 6;

    logic clk = 1'b0;
    logic rst;
    logic preload;
    int   vectors     = 0;
    int   miscompares = 0;
    int   ack_cnt     = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

    dmem_arbiter #(
        .DATA_W(DATA_W), .BASE_ADDR(1024), .DEPTH(DEPTH), .MEM_LAT(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DATA_W-1:0] mem [DEPTH];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'(i);
        end else if (bus.mem_en && bus.mem_we) begin
            mem[bus.mem_idx] <= bus.mem_wdata;
        end
    end

    assign bus.mem_rdata = mem[bus.mem_idx];

    always @(posedge clk) if (bus.dbg_ack) ack_cnt <= ack_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Walk a CPU access while the pipeline is frozen; stop at the first unfrozen cycle.
    task automatic run_cpu(output int fz, output int en, output int we, output logic [31:0] idx);
        fz  = 0;
        en  = 0;
        we  = 0;
        idx = '1;
        for (int i = 0; i < 12; i++) begin
            if (!bus.cpu_freeze) break;
            fz++;
            if (bus.mem_en) begin
                en++;
                idx = 32'(bus.mem_idx);
            end
            if (bus.mem_we) we++;
            step();
        end
    endtask

    task automatic wait_ack(output int cyc);
        cyc = 0;
        while (!bus.dbg_ack && cyc < 12) begin
            step();
            cyc++;
        end
    endtask

    initial begin
        int fz, en, we, cyc, a0;
        logic [31:0] idx;

        rst           = 1'b1;
        preload       = 1'b1;
        bus.cpu_rd_en = 1'b0;
        bus.cpu_wr_en = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.dbg_req   = 1'b0;
        bus.dbg_we    = 1'b0;
        bus.dbg_addr  = '0;
        bus.dbg_wdata = '0;
        step();
        step();
        chk("rst_mem_en",     32'(bus.mem_en),     32'd0);
        chk("rst_mem_we",     32'(bus.mem_we),     32'd0);
        chk("rst_dbg_ack",    32'(bus.dbg_ack),    32'd0);
        chk("rst_mem_idx",    32'(bus.mem_idx),    32'd0);
        chk("rst_cpu_rdata",  bus.cpu_rdata,       32'd0);
        chk("rst_dbg_rdata",  bus.dbg_rdata,       32'd0);
        chk("rst_cpu_freeze", 32'(bus.cpu_freeze), 32'd0);
        preload = 1'b0;
        rst     = 1'b0;
        step();

        // CPU load of word 2
        bus.cpu_rd_en = 1'b1;
        bus.cpu_addr  = 32'h408;
        #1;
        run_cpu(fz, en, we, idx);
        chk("ld_freeze_cycles", 32'(fz), 32'd3);
        chk("ld_en_cycles",     32'(en), 32'd2);
        chk("ld_we_cycles",     32'(we), 32'd0);
        chk("ld_idx",           idx,     32'd2);
        chk("ld_rdata",         bus.cpu_rdata, 32'd2);
        chk("ld_resp_mem_en",   32'(bus.mem_en), 32'd0);
        bus.cpu_rd_en = 1'b0;
        step();

        // CPU store to word 3, then debug read through an unaligned address
        bus.cpu_wr_en = 1'b1;
        bus.cpu_addr  = 32'h40C;
        bus.cpu_wdata = 32'hDEADBEEF;
        #1;
        run_cpu(fz, en, we, idx);
        chk("st_freeze_cycles", 32'(fz), 32'd3);
        chk("st_we_cycles",     32'(we), 32'd2);
        chk("st_idx",           idx,     32'd3);
        chk("st_rdata_kept",    bus.cpu_rdata, 32'd2);
        bus.cpu_wr_en = 1'b0;
        step();
        a0           = ack_cnt;
        bus.dbg_req  = 1'b1;
        bus.dbg_we   = 1'b0;
        bus.dbg_addr = 32'h40F;
        #1;
        wait_ack(cyc);
        chk("dbg_rd_latency", 32'(cyc), 32'd3);
        chk("dbg_rd_rdata",   bus.dbg_rdata, 32'hDEADBEEF);
        bus.dbg_req = 1'b0;
        step();
        chk("dbg_ack_single", 32'(bus.dbg_ack), 32'd0);
        chk("dbg_ack_count",  32'(ack_cnt), 32'(a0 + 1));

        // Contention: CPU wins first, then the pointer favours DBG
        a0            = ack_cnt;
        bus.cpu_rd_en = 1'b1;
        bus.cpu_addr  = 32'h404;
        bus.dbg_req   = 1'b1;
        bus.dbg_addr  = 32'h410;
        #1;
        step();
        chk("rr1_cpu_idx", 32'(bus.mem_idx), 32'd1);
        step();
        step();
        chk("rr1_cpu_unfreeze", 32'(bus.cpu_freeze), 32'd0);
        chk("rr1_cpu_rdata",    bus.cpu_rdata, 32'd1);
        bus.cpu_rd_en = 1'b0;
        step();
        chk("rr1_idle_gap", 32'(bus.mem_en), 32'd0);
        step();
        chk("rr1_dbg_idx", 32'(bus.mem_idx), 32'd4);
        step();
        step();
        chk("rr1_dbg_ack",   32'(bus.dbg_ack), 32'd1);
        chk("rr1_dbg_rdata", bus.dbg_rdata, 32'd4);
        bus.dbg_req = 1'b0;
        step();

        bus.cpu_rd_en = 1'b1;
        bus.cpu_addr  = 32'h408;
        bus.dbg_req   = 1'b1;
        bus.dbg_addr  = 32'h40C;
        #1;
        step();
        chk("rr2_dbg_idx", 32'(bus.mem_idx), 32'd3);
        step();
        step();
        chk("rr2_dbg_ack",       32'(bus.dbg_ack), 32'd1);
        chk("rr2_dbg_rdata",     bus.dbg_rdata, 32'hDEADBEEF);
        chk("rr2_cpu_still_frz", 32'(bus.cpu_freeze), 32'd1);
        bus.dbg_req = 1'b0;
        step();
        step();
        chk("rr2_cpu_idx", 32'(bus.mem_idx), 32'd2);
        step();
        step();
        chk("rr2_cpu_unfreeze", 32'(bus.cpu_freeze), 32'd0);
        chk("rr2_cpu_rdata",    bus.cpu_rdata, 32'd2);
        chk("rr_ack_count",     32'(ack_cnt), 32'(a0 + 2));
        bus.cpu_rd_en = 1'b0;
        step();

        // Reset during the first ACCESS cycle aborts the debug read
        bus.dbg_req  = 1'b1;
        bus.dbg_we   = 1'b0;
        bus.dbg_addr = 32'h414;
        #1;
        step();
        chk("abort_pre_en", 32'(bus.mem_en), 32'd1);
        a0  = ack_cnt;
        rst = 1'b1;
        #1;
        chk("abort_mem_en",  32'(bus.mem_en),  32'd0);
        chk("abort_dbg_ack", 32'(bus.dbg_ack), 32'd0);
        chk("abort_rdata",   bus.dbg_rdata,    32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("abort_idle", 32'(bus.mem_en), 32'd0);
        wait_ack(cyc);
        chk("abort_retry_latency", 32'(cyc), 32'd3);
        chk("abort_retry_rdata",   bus.dbg_rdata, 32'd5);
        bus.dbg_req = 1'b0;
        step();
        chk("abort_ack_count", 32'(ack_cnt), 32'(a0 + 1));

        // Address below the memory window
        bus.cpu_rd_en = 1'b1;
        bus.cpu_addr  = 32'h300;
        #1;
        run_cpu(fz, en, we, idx);
`ifdef DMEM_RANGE_CHECK_EN
        chk("oor_freeze_cycles", 32'(fz), 32'd1);
        chk("oor_en_cycles",     32'(en), 32'd0);
        chk("oor_range_err",     32'(bus.range_err), 32'd1);
        chk("oor_rdata",         bus.cpu_rdata, 32'd0);
        bus.cpu_rd_en = 1'b0;
        step();
        chk("oor_range_err_clr", 32'(bus.range_err), 32'd0);
`else
        chk("wrap_freeze_cycles", 32'(fz), 32'd3);
        chk("wrap_en_cycles",     32'(en), 32'd2);
        chk("wrap_idx",           idx,     32'd0);
        chk("wrap_rdata",         bus.cpu_rdata, 32'd0);
        bus.cpu_rd_en = 1'b0;
        step();
`endif

        // Read and write together behave as a write
        bus.cpu_rd_en = 1'b1;
        bus.cpu_wr_en = 1'b1;
        bus.cpu_addr  = 32'h404;
        bus.cpu_wdata = 32'h55;
        #1;
        run_cpu(fz, en, we, idx);
        chk("rw_freeze_cycles", 32'(fz), 32'd3);
        chk("rw_we_cycles",     32'(we), 32'd2);
        chk("rw_idx",           idx,     32'd1);
        chk("rw_rdata_kept",    bus.cpu_rdata, 32'd0);
        bus.cpu_rd_en = 1'b0;
        bus.cpu_wr_en = 1'b0;
        step();
        bus.dbg_req  = 1'b1;
        bus.dbg_we   = 1'b0;
        bus.dbg_addr = 32'h404;
        #1;
        wait_ack(cyc);
        chk("rw_readback_latency", 32'(cyc), 32'd3);
        chk("rw_readback",         bus.dbg_rdata, 32'h55);
        bus.dbg_req = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
